spectrum_sram_fifo_ctrl: RTL and testbench



---
 rtl/spectrum_fifo_pkg.sv | 20 ++
 rtl/fifo_prefetch_buf.sv | 54 +++++
 rtl/spectrum_sram_fifo_ctrl.sv | 106 ++++++++++
 tb/tb_spectrum_sram_fifo_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spectrum_fifo_pkg.sv
// ============================================================================
// Module : spectrum_fifo_pkg
// Brief  : Shared sizing constants for the spectrum SRAM streaming FIFO.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package spectrum_fifo_pkg;

    localparam int unsigned c_DATA_W      = 32;
    localparam int unsigned c_ADDR_W      = 9;
    localparam int unsigned c_DEPTH       = 512;
    localparam int unsigned c_CNT_W       = 10;
    // Output-side register stage depth; sized so one read can be outstanding
    // while the head word is being consumed.
    localparam int unsigned c_PF_DEPTH    = 2;

endpackage

`default_nettype wire

// File: rtl/fifo_prefetch_buf.sv
// ============================================================================
// Module : fifo_prefetch_buf
// Brief  : 2-entry register FIFO holding words prefetched from the SRAM.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fifo_prefetch_buf
    import spectrum_fifo_pkg::*;
#(
    parameter int unsigned DATA_W = c_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clear,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_push_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_head_data,
    output logic [1:0]        o_cnt
);

    logic [DATA_W-1:0] r_mem [0:c_PF_DEPTH-1];
    logic              r_head;
    logic              r_tail;
    logic [1:0]        r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_head <= 1'b0;
            r_tail <= 1'b0;
            r_cnt  <= 2'd0;
        end else begin
            if (i_push) begin
                r_mem[r_tail] <= i_push_data;
                r_tail        <= ~r_tail;
            end
            if (i_pop) begin
                r_head <= ~r_head;
            end
            case ({i_push, i_pop})
                2'b10:   r_cnt <= r_cnt + 2'd1;
                2'b01:   r_cnt <= r_cnt - 2'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign o_head_data = r_mem[r_head];
    assign o_cnt       = r_cnt;

endmodule

`default_nettype wire

// File: rtl/spectrum_sram_fifo_ctrl.sv
// ============================================================================
// Module : spectrum_sram_fifo_ctrl
// Brief  : Streaming FIFO controller for a 512x32 1W/1R SRAM with read prefetch.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module spectrum_sram_fifo_ctrl
    import spectrum_fifo_pkg::*;
#(
    parameter int unsigned DATA_W = c_DATA_W,
    parameter int unsigned ADDR_W = c_ADDR_W,
    parameter int unsigned DEPTH  = c_DEPTH,
    parameter int unsigned CNT_W  = c_CNT_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_bits,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_bits,
    output logic [CNT_W-1:0]  count,
    output logic              mem_W0_en,
    output logic [ADDR_W-1:0] mem_W0_addr,
    output logic [DATA_W-1:0] mem_W0_data,
    output logic              mem_R0_en,
    output logic [ADDR_W-1:0] mem_R0_addr,
    input  logic [DATA_W-1:0] mem_R0_data
);

    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_sram_cnt;
    logic              r_inflight;

    logic [1:0]        w_buf_cnt;
    logic [DATA_W-1:0] w_buf_head;
    logic              w_in_fire;
    logic              w_out_fire;
    logic              w_rd_go;
    logic [2:0]        w_occ;
    logic              w_active;

    assign w_active   = ~reset & ~flush;
    assign in_ready   = w_active & (r_sram_cnt < (ADDR_W+1)'(DEPTH));
    assign w_in_fire  = in_valid & in_ready;
    assign out_valid  = (w_buf_cnt != 2'd0);
    assign w_out_fire = out_valid & out_ready;

    // Buffer slots committed after this edge; a new read may only be issued
    // if its data will still have a free slot when it returns.
    assign w_occ   = 3'(w_buf_cnt) + 3'(r_inflight) - 3'(w_out_fire);
    assign w_rd_go = w_active & (r_sram_cnt != '0) & (w_occ < 3'(c_PF_DEPTH));

    assign mem_W0_en   = w_in_fire;
    assign mem_W0_addr = r_wr_ptr;
    assign mem_W0_data = in_bits;
    assign mem_R0_en   = w_rd_go;
    assign mem_R0_addr = r_rd_ptr;

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_sram_cnt <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_rd_go;
            if (w_in_fire) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end
            if (w_rd_go) begin
                r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            end
            case ({w_in_fire, w_rd_go})
                2'b10:   r_sram_cnt <= r_sram_cnt + (ADDR_W+1)'(1);
                2'b01:   r_sram_cnt <= r_sram_cnt - (ADDR_W+1)'(1);
                default: r_sram_cnt <= r_sram_cnt;
            endcase
        end
    end

    // A flush also clears the buffer, so data returning from a read issued
    // before the flush is discarded rather than captured.
    fifo_prefetch_buf #(
        .DATA_W (DATA_W)
    ) u_prefetch_buf (
        .clk         (clock),
        .rst         (reset),
        .i_clear     (flush),
        .i_push      (r_inflight),
        .i_push_data (mem_R0_data),
        .i_pop       (w_out_fire),
        .o_head_data (w_buf_head),
        .o_cnt       (w_buf_cnt)
    );

    assign out_bits = w_buf_head;
    assign count    = CNT_W'(r_sram_cnt) + CNT_W'(r_inflight) + CNT_W'(w_buf_cnt);

endmodule

`default_nettype wire

// File: tb/tb_spectrum_sram_fifo_ctrl.sv
// ============================================================================
// Module : tb_spectrum_sram_fifo_ctrl
// Brief  : Directed self-checking bench with a 1-cycle-latency SRAM model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_spectrum_sram_fifo_ctrl;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_bits;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_bits;
    logic [9:0]  count;
    logic        mem_W0_en;
    logic [8:0]  mem_W0_addr;
    logic [31:0] mem_W0_data;
    logic        mem_R0_en;
    logic [8:0]  mem_R0_addr;
    logic [31:0] mem_R0_data;

    logic [31:0] sram [0:511];

    int n_checks = 0;
    int n_fail   = 0;
    int wr_idx;
    int rd_idx;
    int n_rd;
    int cycles;

    spectrum_sram_fifo_ctrl dut (
        .clock       (clk),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_bits     (in_bits),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_bits    (out_bits),
        .count       (count),
        .mem_W0_en   (mem_W0_en),
        .mem_W0_addr (mem_W0_addr),
        .mem_W0_data (mem_W0_data),
        .mem_R0_en   (mem_R0_en),
        .mem_R0_addr (mem_R0_addr),
        .mem_R0_data (mem_R0_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (mem_W0_en) sram[mem_W0_addr] <= mem_W0_data;
        if (mem_R0_en) mem_R0_data <= sram[mem_R0_addr];
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_bits = '0; out_ready = 1'b0;
        mid();
        check_eq("rst_in_ready", 32'(in_ready), 0);
        check_eq("rst_w0_en", 32'(mem_W0_en), 0);
        edge1(); reset = 1'b0;
        mid();
        check_eq("post_rst_count", 32'(count), 0);
        check_eq("post_rst_out_valid", 32'(out_valid), 0);
        check_eq("post_rst_in_ready", 32'(in_ready), 1);
        check_eq("post_rst_r0_en", 32'(mem_R0_en), 0);

        // Single word latency: write t, read t+1, visible t+3.
        edge1(); in_valid = 1'b1; in_bits = 32'hDEADBEEF; out_ready = 1'b1;
        mid();
        check_eq("single_w0_en", 32'(mem_W0_en), 1);
        check_eq("single_w0_addr", 32'(mem_W0_addr), 0);
        check_eq("single_w0_data", mem_W0_data, 32'hDEADBEEF);
        check_eq("single_r0_en_t0", 32'(mem_R0_en), 0);
        edge1(); in_valid = 1'b0;
        mid();
        check_eq("single_r0_en_t1", 32'(mem_R0_en), 1);
        check_eq("single_r0_addr_t1", 32'(mem_R0_addr), 0);
        check_eq("single_count_t1", 32'(count), 1);
        check_eq("single_w0_en_t1", 32'(mem_W0_en), 0);
        edge1(); mid();
        check_eq("single_out_valid_t2", 32'(out_valid), 0);
        check_eq("single_count_t2", 32'(count), 1);
        edge1(); mid();
        check_eq("single_out_valid_t3", 32'(out_valid), 1);
        check_eq("single_out_bits_t3", out_bits, 32'hDEADBEEF);
        edge1(); mid();
        check_eq("single_out_valid_t4", 32'(out_valid), 0);
        check_eq("single_count_t4", 32'(count), 0);

        // Fill with downstream stalled.
        out_ready = 1'b0; wr_idx = 0; n_rd = 0;
        for (int i = 0; i < 600; i++) begin
            edge1(); in_valid = 1'b1; in_bits = 32'(wr_idx);
            mid();
            if (mem_R0_en) n_rd++;
            if (in_ready) wr_idx++;
        end
        check_eq("fill_accepted", 32'(wr_idx), 514);
        check_eq("fill_reads", 32'(n_rd), 2);
        check_eq("fill_count", 32'(count), 514);
        check_eq("fill_in_ready", 32'(in_ready), 0);
        check_eq("fill_r0_en", 32'(mem_R0_en), 0);
        check_eq("fill_out_valid", 32'(out_valid), 1);
        check_eq("fill_head", out_bits, 0);

        // Drain from full with simultaneous writes: one word per cycle.
        rd_idx = 0;
        for (int i = 0; i < 40; i++) begin
            edge1(); in_valid = 1'b1; in_bits = 32'(wr_idx); out_ready = 1'b1;
            mid();
            check_eq("drain_out_valid", 32'(out_valid), 1);
            check_eq("drain_out_bits", out_bits, 32'(rd_idx));
            check_eq("drain_count_range", 32'(count >= 10'd513 && count <= 10'd514), 1);
            rd_idx++;
            if (in_ready) wr_idx++;
        end
        check_eq("drain_count_steady", 32'(count), 513);

        edge1(); flush = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        mid();
        check_eq("flush_in_ready", 32'(in_ready), 0);
        check_eq("flush_r0_en", 32'(mem_R0_en), 0);
        edge1(); flush = 1'b0;
        mid();
        check_eq("flush_count", 32'(count), 0);
        check_eq("flush_out_valid", 32'(out_valid), 0);

        // Random handshake stream; pointers wrap nearly three times.
        wr_idx = 0; rd_idx = 0; cycles = 0;
        while (rd_idx < 1500 && cycles < 20000) begin
            edge1();
            in_valid  = (wr_idx < 1500) && ($urandom_range(0, 1) == 1);
            in_bits   = 32'(wr_idx);
            out_ready = ($urandom_range(0, 1) == 1);
            mid();
            if (in_valid && in_ready) wr_idx++;
            if (out_valid && out_ready) begin
                check_eq("rand_out_bits", out_bits, 32'(rd_idx));
                rd_idx++;
            end
            cycles++;
        end
        check_eq("rand_total_out", 32'(rd_idx), 1500);
        edge1(); in_valid = 1'b0; out_ready = 1'b0;
        mid();
        check_eq("rand_end_count", 32'(count), 0);
        check_eq("rand_end_out_valid", 32'(out_valid), 0);

        // Flush with a read in flight and the buffer about to hold two words.
        for (int i = 0; i < 3; i++) begin
            edge1(); in_valid = 1'b1; in_bits = 32'h100 + 32'(i);
            mid();
        end
        edge1(); in_valid = 1'b0; flush = 1'b1;
        mid();
        check_eq("preflush_count", 32'(count), 3);
        edge1(); flush = 1'b0;
        mid();
        check_eq("postflush_count", 32'(count), 0);
        check_eq("postflush_out_valid", 32'(out_valid), 0);
        check_eq("postflush_in_ready", 32'(in_ready), 1);
        edge1(); in_valid = 1'b1; in_bits = 32'h5;
        mid();
        check_eq("f5_w0_addr", 32'(mem_W0_addr), 0);
        edge1(); in_valid = 1'b0;
        mid();
        check_eq("f5_r0_addr", 32'(mem_R0_addr), 0);
        check_eq("f5_out_valid_t1", 32'(out_valid), 0);
        edge1(); mid();
        check_eq("f5_out_valid_t2", 32'(out_valid), 0);
        edge1(); out_ready = 1'b1;
        mid();
        check_eq("f5_out_valid_t3", 32'(out_valid), 1);
        check_eq("f5_out_bits_t3", out_bits, 32'h5);
        edge1(); mid();
        check_eq("f5_out_valid_t4", 32'(out_valid), 0);
        check_eq("f5_count_t4", 32'(count), 0);

        // Reset mid-stream with a word offered.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            edge1(); in_valid = 1'b1; in_bits = 32'h200 + 32'(i);
            mid();
        end
        edge1(); reset = 1'b1; in_bits = 32'hBAD;
        mid();
        check_eq("midrst_in_ready", 32'(in_ready), 0);
        check_eq("midrst_w0_en", 32'(mem_W0_en), 0);
        check_eq("midrst_r0_en", 32'(mem_R0_en), 0);
        edge1(); reset = 1'b0; in_bits = 32'h77;
        mid();
        check_eq("midrst_count", 32'(count), 0);
        check_eq("midrst_out_valid", 32'(out_valid), 0);
        check_eq("midrst_w0_en_after", 32'(mem_W0_en), 1);
        check_eq("midrst_w0_addr_after", 32'(mem_W0_addr), 0);
        edge1(); in_valid = 1'b0;
        mid();
        check_eq("midrst_r0_en_after", 32'(mem_R0_en), 1);
        check_eq("midrst_r0_addr_after", 32'(mem_R0_addr), 0);
        edge1(); mid();
        edge1(); out_ready = 1'b1;
        mid();
        check_eq("midrst_out_valid_t3", 32'(out_valid), 1);
        check_eq("midrst_out_bits_t3", out_bits, 32'h77);
        edge1(); mid();
        check_eq("midrst_out_valid_t4", 32'(out_valid), 0);
        check_eq("midrst_count_t4", 32'(count), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
